// File: rtl/msg_packer.sv
// Byte-stream to flat message packer for the HDC classifier; msg_valid is seen the cycle after the in_last beat.
// in_ready drops while a packed message waits in HOLD for msg_ack; beats past MAX_LENGTH are accepted and discarded.
module msg_packer #(
  parameter int MAX_LENGTH = 160,
  parameter int CHAR_W     = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [CHAR_W-1:0]            in_char,
  input  logic                         in_valid,
  input  logic                         in_last,
  output logic                         in_ready,
  output logic [MAX_LENGTH*CHAR_W-1:0] msg,
  output logic [7:0]                   length,
  output logic                         msg_valid,
  input  logic                         msg_ack,
  output logic                         overflow
);

  typedef enum logic [1:0] {FILL, DROP, HOLD} state_e;

  localparam logic [7:0] MAX_L = 8'(MAX_LENGTH);

  state_e                         state_q, state_d;
  logic [7:0]                     count_q, count_d;
  logic [MAX_LENGTH*CHAR_W-1:0]   msg_q, msg_d;
  logic [7:0]                     len_q, len_d;
  logic                           ovf_q, ovf_d;
  logic                           live_q;
  logic                           beat;
  int                             wr_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FILL;
      count_q <= '0;
      msg_q   <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      msg_q   <= msg_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
      live_q  <= 1'b1;
    end
  end

  // live_q holds in_ready low until the first edge after reset is released.
  assign in_ready  = live_q && (state_q != HOLD);
  assign msg_valid = (state_q == HOLD);
  assign msg       = msg_q;
  assign length    = len_q;
  assign overflow  = ovf_q;
  assign beat      = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    msg_d   = msg_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    wr_idx  = int'(count_q) * CHAR_W;
    unique case (state_q)
      FILL: begin
        if (beat) begin
          if (count_q < MAX_L) msg_d[wr_idx +: CHAR_W] = in_char;
          count_d = count_q + 8'd1;
          if (in_last) begin
            len_d   = count_q + 8'd1;
            state_d = HOLD;
          end else if (count_q + 8'd1 == MAX_L) begin
            state_d = DROP;
          end
        end
      end
      DROP: begin
        // count_q stays saturated at MAX_LENGTH here.
        if (beat) begin
          ovf_d = 1'b1;
          if (in_last) begin
            len_d   = MAX_L;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (msg_ack) begin
          msg_d   = '0;
          count_d = '0;
          len_d   = '0;
          ovf_d   = 1'b0;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

endmodule

// File: tb/tb_msg_packer.sv
// Directed and randomized bench for msg_packer against a queue-based model of the sent characters.
module tb_msg_packer;
  localparam int ML = 160;
  localparam int W  = ML * 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   in_char;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic [W-1:0] msg;
  logic [7:0]   length;
  logic         msg_valid;
  logic         msg_ack;
  logic         overflow;

  int tests = 0;
  int fails = 0;
  byte unsigned sent[$];

  msg_packer #(.MAX_LENGTH(ML), .CHAR_W(8)) dut (
    .clk(clk), .reset(reset), .in_char(in_char), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .msg(msg), .length(length),
    .msg_valid(msg_valid), .msg_ack(msg_ack), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero_outs(input string tag);
    chk({tag, "_msg"}, msg, '0);
    chk({tag, "_length"}, W'(length), '0);
    chk({tag, "_overflow"}, W'(overflow), '0);
    chk({tag, "_msg_valid"}, W'(msg_valid), '0);
  endtask

  // Model: first min(n, ML) characters land at byte k, the rest are dropped.
  task automatic check_msg(input string tag);
    logic [W-1:0] exp_msg;
    int n, kept;
    n = sent.size();
    kept = (n > ML) ? ML : n;
    exp_msg = '0;
    for (int k = 0; k < kept; k++) exp_msg[k*8 +: 8] = sent[k];
    chk({tag, "_msg"}, msg, exp_msg);
    chk({tag, "_length"}, W'(length), W'(kept));
    chk({tag, "_overflow"}, W'(overflow), W'(n > ML));
    chk({tag, "_msg_valid"}, W'(msg_valid), W'(1));
  endtask

  task automatic beat(input logic [7:0] c, input bit last, input int gap);
    in_valid = 1'b1;
    in_char  = c;
    in_last  = last;
    chk("in_ready_at_beat", W'(in_ready), W'(1));
    @(posedge clk); #1;
    sent.push_back(c);
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk(last ? "msg_valid_latency" : "msg_valid_low_mid", W'(msg_valid), W'(last));
    repeat (gap) begin
      in_char = 8'($urandom);
      in_last = 1'($urandom);
      @(posedge clk); #1;
    end
    in_last = 1'b0;
  endtask

  task automatic hold_ack(input int delay, input bit push);
    for (int i = 0; i < delay; i++) begin
      in_valid = push;
      in_char  = 8'($urandom);
      in_last  = 1'($urandom);
      @(posedge clk); #1;
      chk("hold_in_ready", W'(in_ready), '0);
      check_msg("hold_frozen");
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    msg_ack  = 1'b1;
    @(posedge clk); #1;
    msg_ack  = 1'b0;
    chk_zero_outs("after_ack");
    chk("after_ack_in_ready", W'(in_ready), W'(1));
    sent.delete();
  endtask

  task automatic send_msg(input int n, input int gapmax);
    for (int i = 0; i < n; i++)
      beat(8'($urandom), i == n - 1, $urandom_range(0, gapmax));
  endtask

  initial begin
    reset = 1'b1; in_char = '0; in_valid = 1'b0; in_last = 1'b0; msg_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero_outs("reset");
    chk("reset_in_ready", W'(in_ready), '0);
    reset = 1'b0;
    #1;
    chk("release_in_ready_pre_edge", W'(in_ready), '0);
    @(posedge clk); #1;
    chk("release_in_ready", W'(in_ready), W'(1));

    // Reset mid-message, then "Hi".
    beat(8'h11, 0, 0); beat(8'h22, 0, 0); beat(8'h33, 0, 0);
    reset = 1'b1;
    #1;
    chk_zero_outs("mid_reset");
    chk("mid_reset_in_ready", W'(in_ready), '0);
    @(posedge clk); #1;
    reset = 1'b0;
    sent.delete();
    @(posedge clk); #1;
    chk("mid_release_in_ready", W'(in_ready), W'(1));
    beat(8'h48, 0, 0); beat(8'h69, 1, 0);
    check_msg("hi");
    chk("hi_low16", W'(msg[15:0]), W'(16'h6948));
    hold_ack(0, 0);

    // Gapped "ham".
    beat(8'h68, 0, 2); beat(8'h61, 0, 2); beat(8'h6D, 1, 0);
    check_msg("ham");
    chk("ham_low24", W'(msg[23:0]), W'(24'h6D6168));
    hold_ack(1, 0);

    // Exact fill.
    for (int i = 0; i < ML; i++) beat(8'h41, i == ML - 1, 0);
    check_msg("exact");
    chk("exact_length", W'(length), W'(160));
    hold_ack(0, 0);

    // Overflow with HOLD backpressure.
    for (int i = 0; i < ML + 3; i++) beat(8'(i % 256), i == ML + 2, 0);
    check_msg("ovf");
    chk("ovf_top_byte", W'(msg[W-1 -: 8]), W'(8'h9F));
    chk("ovf_flag", W'(overflow), W'(1));
    hold_ack(5, 1);

    // Next beat right after ack lands at byte 0; spurious ack in FILL.
    beat(8'hA5, 0, 0); beat(8'h5A, 0, 0);
    msg_ack = 1'b1;
    @(posedge clk); #1;
    msg_ack = 1'b0;
    chk("spurious_ack_msg_valid", W'(msg_valid), '0);
    chk("spurious_ack_in_ready", W'(in_ready), W'(1));
    beat(8'hC3, 1, 0);
    check_msg("spurious");
    chk("spurious_length", W'(length), W'(3));
    hold_ack(2, 1);

    // Randomized messages around and beyond the capacity.
    for (int m = 0; m < 12; m++) begin
      int n;
      n = (m % 3 == 0) ? $urandom_range(ML - 2, ML + 12) : $urandom_range(1, ML + 15);
      send_msg(n, $urandom_range(0, 2));
      check_msg("rand");
      hold_ack($urandom_range(0, 4), 1'($urandom));
    end

    // Reset while holding a message.
    send_msg(5, 0);
    check_msg("pre_hold_reset");
    reset = 1'b1;
    #1;
    chk_zero_outs("hold_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    sent.delete();
    @(posedge clk); #1;
    chk("hold_reset_in_ready", W'(in_ready), W'(1));
    send_msg(4, 1);
    check_msg("post_reset");
    hold_ack(0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
